// File: rtl/sram_clr.sv
// Single-port synchronous SRAM with a registered read port and a clear sequencer
// that fills every word with CLR_VAL after reset or on a clr request.
module sram_clr #(
    parameter int                 ADDR_W  = 12,
    parameter int                 DATA_W  = 4,
    parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              we_b,
    input  logic              e_b,
    input  logic              clr,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = addr;
        mem_wdata  = data_in;

        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = CLR_VAL;
            clr_ptr_d = clr_ptr_q + PTR_ONE;
            if (clr_ptr_q == {ADDR_W{1'b1}}) begin
                state_d = READY;
            end
        end else begin
            if (!e_b) begin
                if (!we_b) begin
                    mem_we = 1'b1;
                end else begin
                    data_out_d = mem[addr];
                    rd_valid_d = 1'b1;
                end
            end
            // The access above still completes; the clear starts next cycle.
            if (clr) begin
                state_d   = CLEAR;
                clr_ptr_d = '0;
            end
        end

        // Reset drops whatever write was decoded this cycle.
        if (rst) begin
            mem_we = 1'b0;
        end

        busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;

endmodule
